prio_irq_encoder: RTL and testbench
===================================

Name: prio_irq_encoder

Overview:
- Sequential priority encoder. It is the encoding counterpart to the team's casez priority decoders.
- Captures rising edges on a request vector into sticky pending bits.
- Presents the index of the highest-priority unmasked pending request with a valid/ack handshake, and clears that bit on acknowledge.
- Sits between peripheral request lines and a single consumer, such as a CPU interrupt port or a test sequencer.

Parameters:
- N, 8, number of request lines (2..32).
- IDW, $clog2(N), width of the encoded index. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- req  input  N  level request lines. Bit i rising 0->1 creates pending event i.
- mask  input  N  1 = line ignored for selection. Its pending bit still sets.
- ack  input  1  consumer accepts the presented index. Sampled only while valid_o=1.
- valid_o  output  1  id_o holds a valid encoded request.
- id_o  output  IDW  encoded index of the presented request.
- pend_o  output  N  current pending register.
- overflow_o  output  1  one-cycle pulse: a rising edge hit a line whose pending bit was already set.

Behaviour:
- Reset, asynchronous on rstn=0:
  - Outputs: valid_o=0, id_o=0, pend_o=0, overflow_o=0.
  - Internal: req_q=0, state=IDLE.
  - Reset assertion in any state aborts the transaction. Nothing is retained.
- Edge detect: edge = req & ~req_q, with req_q registered every cycle. An edge on req at posedge k sets pend[i] at posedge k.
- Priority: lowest index wins; bit 0 is highest. Candidates are pend & ~mask.
- State machine, states IDLE, PRESENT, GAP:
  - IDLE: if candidates != 0 at posedge, latch id_o = lowest set index, set valid_o=1, go to PRESENT. Latency from req edge to valid_o is 2 posedges.
  - PRESENT: id_o and valid_o are held stable; changes to mask or pend do not retract or change the presented id. On ack=1 at posedge: clear pend[id_o], set valid_o=0, go to GAP.
  - GAP: one cycle with valid_o=0, then IDLE. This guarantees at least one idle cycle between presentations.
- ack while valid_o=0 is ignored and has no side effects.
- Simultaneous set and clear of the same bit (edge on line id_o in the ack cycle): set wins, so pend[id_o] stays 1 and overflow_o does not pulse.
- Overflow: overflow_o=1 for one cycle when an edge arrives and pend[i] was already 1, except in the simultaneous set-and-clear case above.
- All-masked pending: stay in IDLE with valid_o=0. Pending bits are retained and presented once unmasked.
- X/unknown on req or mask must not be silently treated as 0. Add an assertion that errors on X in req, mask, or ack while out of reset.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Package prio_irq_pkg:
  - typedef enum logic [1:0] {IDLE, PRESENT, GAP} pie_state_e.
  - function lowest_set_index(vector, N), returning the index and a found flag. Implement it as a for-loop priority search, not casez, so it is N-generic.
- Sub-module req_edge_detect, parameter N: holds req_q and outputs edge. Reusable by other request-capture blocks.

Test Plan:
- Reset then single request: req=8'h04 held → valid_o=1, id_o=2 two posedges after the edge. ack=1 for 1 cycle → pend_o=0, valid_o=0 for ≥1 cycle.
- Priority ordering: req edge 8'h90 in one cycle → id_o=4 first, then after ack and GAP id_o=7. pend_o goes 8'h90 → 8'h80 → 8'h00.
- Masking: mask=8'h01 and req edge 8'h03 → id_o=1. Clear mask after ack → id_o=0 presented next.
- Hold stability: while PRESENT with id_o=5, raise req bit 0 → id_o stays 5 until ack, then 0 is presented after GAP.
- Overflow and set-wins: edge on line 3 twice without ack → overflow_o pulses once. Edge on line 3 in its ack cycle → pend_o[3] stays 1, no overflow pulse.
- Reset mid-operation: assert rstn=0 during PRESENT with pend_o=8'hFF → all outputs 0 immediately. Release with req held high → no new events until a fresh 0→1 edge.

Source files
------------

// File: rtl/prio_irq_encoder_pkg.sv
// Shared types and helpers for the sequential priority interrupt encoder.
package prio_irq_pkg;

    // Widest request vector the helper search supports.
    localparam int MAXN = 32;
    localparam int MAXIDW = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } pie_state_e;

    // Result of a priority search: index of the lowest set bit plus a found flag.
    typedef struct packed {
        logic              found;
        logic [MAXIDW-1:0] idx;
    } lsi_t;

    // Lowest index wins. Bits at or above n are ignored so the same search
    // serves any request width up to MAXN.
    function automatic lsi_t lowest_set_index(input logic [MAXN-1:0] vec, input int n);
        lsi_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = MAXN - 1; i >= 0; i--) begin
            if (i < n && vec[i]) begin
                r.found = 1'b1;
                r.idx   = MAXIDW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_irq_encoder_if.sv
// Request/handshake bundle between request sources, the encoder and its consumer.
//
// Handshake: valid_o=1 means id_o names a pending request and stays stable
// until the consumer raises ack for one cycle; the pending bit is cleared at
// that edge. ack while valid_o=0 is ignored.
interface prio_irq_encoder_if
    import prio_irq_pkg::*;
#(
    parameter int N = 8
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   mask;
    logic           ack;
    logic           valid_o;
    logic [IDW-1:0] id_o;
    logic [N-1:0]   pend_o;
    logic           overflow_o;
    pie_state_e     state_dbg;

    modport master (
        output req, mask, ack,
        input  valid_o, id_o, pend_o, overflow_o, state_dbg
    );

    modport slave (
        input  req, mask, ack,
        output valid_o, id_o, pend_o, overflow_o, state_dbg
    );

endinterface

// File: rtl/prio_irq_encoder_req_edge_detect.sv
// Rising-edge detector for a vector of level request lines.
// The first cycle after reset only primes req_q, so lines already high when
// reset is released do not produce events.
module req_edge_detect #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    output logic [N-1:0] rise
);

    logic [N-1:0] req_q;
    logic         armed;

    // Track previous request levels; arm detection one cycle after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q <= '0;
            armed <= 1'b0;
        end else begin
            req_q <= req;
            armed <= 1'b1;
        end
    end

    assign rise = armed ? (req & ~req_q) : '0;

endmodule

// File: rtl/prio_irq_encoder.sv
// Sequential priority encoder: captures request edges into sticky pending
// bits and presents the lowest-index unmasked one over a valid/ack handshake.
module prio_irq_encoder
    import prio_irq_pkg::*;
#(
    parameter int N = 8
) (
    input logic              clk,
    input logic              rstn,
    prio_irq_encoder_if.slave bus
);

    localparam int IDW = $clog2(N);

    pie_state_e     state;
    logic           valid_q;
    logic [IDW-1:0] id_q;
    logic [N-1:0]   pend;
    logic           ovf_q;

    logic [N-1:0]   rise;
    logic [N-1:0]   clr;
    logic [N-1:0]   pend_nxt;
    logic [N-1:0]   cand;
    logic           ovf_nxt;
    lsi_t           pick;

    req_edge_detect #(.N(N)) u_edge (
        .clk  (clk),
        .rstn (rstn),
        .req  (bus.req),
        .rise (rise)
    );

    // Pending update: clear the acknowledged bit, then OR in new edges so a
    // simultaneous set on the same line wins and is not an overflow.
    always_comb begin
        clr = '0;
        if (state == PRESENT && bus.ack) begin
            clr[id_q] = 1'b1;
        end
        pend_nxt = (pend & ~clr) | rise;
        ovf_nxt  = |(rise & pend & ~clr);
        cand     = pend & ~bus.mask;
        pick     = lowest_set_index(MAXN'(cand), N);
    end

    // Pending register and overflow pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend  <= '0;
            ovf_q <= 1'b0;
        end else begin
            pend  <= pend_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    // Presentation FSM: latch an index, hold it until ack, then one idle cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick.found) begin
                        id_q    <= IDW'(pick.idx);
                        valid_q <= 1'b1;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.ack) begin
                        valid_q <= 1'b0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.id_o       = id_q;
    assign bus.pend_o     = pend;
    assign bus.overflow_o = ovf_q;
    assign bus.state_dbg  = state;

    // Unknown inputs must never be quietly read as zero.
    a_no_x_inputs: assert property (@(posedge clk) disable iff (!rstn)
        !$isunknown({bus.req, bus.mask, bus.ack}))
        else $error("unknown value on req/mask/ack");

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Directed bench for prio_irq_encoder with an id scoreboard and direct
// checks of pending, overflow and handshake timing.
module tb_prio_irq_encoder;
    import prio_irq_pkg::*;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic clk;
    logic rstn;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic         seen_valid = 1'b0;

    prio_irq_encoder_if #(.N(N)) bus ();

    prio_irq_encoder #(.N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.valid_o && n < 20) begin
            tick();
            n++;
        end
        if (!bus.valid_o) begin
            total++;
            bad++;
            $display("FAIL %s: got valid_o=0 after %0d cycles, required valid_o=1", name, n);
        end
    endtask

    task automatic ack_one(input string name);
        wait_valid(name);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    // monitor: each new presentation is compared against the expected queue
    always @(negedge clk) begin
        if (rstn && bus.valid_o && !seen_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL id_unexpected: got id %0d, required no presentation", bus.id_o);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (bus.id_o !== e) begin
                    bad++;
                    $display("FAIL id_order: got id %0d, required %0d", bus.id_o, e);
                end
            end
        end
        seen_valid <= rstn && bus.valid_o;
    end

    initial begin
        bus.req  = '0;
        bus.mask = '0;
        bus.ack  = 1'b0;
        rstn     = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(bus.valid_o), 0);
        check("rst_id", 32'(bus.id_o), 0);
        check("rst_pend", 32'(bus.pend_o), 0);
        check("rst_ovf", 32'(bus.overflow_o), 0);
        check("rst_state", 32'(bus.state_dbg), 32'(IDLE));
        rstn = 1'b1;
        repeat (2) tick();

        // single request, latency and ack
        exp_q.push_back(W'(2));
        bus.req = 8'h04;
        tick();
        check("single_pend_set", 32'(bus.pend_o), 32'h04);
        check("single_not_yet_valid", 32'(bus.valid_o), 0);
        tick();
        check("single_valid_2edges", 32'(bus.valid_o), 1);
        check("single_id", 32'(bus.id_o), 2);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("single_pend_clr", 32'(bus.pend_o), 0);
        check("single_valid_drop", 32'(bus.valid_o), 0);
        tick();
        check("single_gap", 32'(bus.valid_o), 0);
        bus.req = '0;
        tick();

        // stray ack while idle has no effect
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("idle_ack_pend", 32'(bus.pend_o), 0);
        check("idle_ack_valid", 32'(bus.valid_o), 0);

        // priority ordering
        exp_q.push_back(W'(4));
        exp_q.push_back(W'(7));
        bus.req = 8'h90;
        tick();
        check("prio_pend_both", 32'(bus.pend_o), 32'h90);
        ack_one("prio_first");
        check("prio_pend_after1", 32'(bus.pend_o), 32'h80);
        ack_one("prio_second");
        check("prio_pend_after2", 32'(bus.pend_o), 32'h00);
        bus.req = '0;
        tick();

        // masking, all-masked pending retained
        bus.mask = 8'h01;
        exp_q.push_back(W'(1));
        bus.req = 8'h03;
        tick();
        ack_one("mask_first");
        repeat (4) tick();
        check("mask_hold_valid", 32'(bus.valid_o), 0);
        check("mask_hold_pend", 32'(bus.pend_o), 32'h01);
        exp_q.push_back(W'(0));
        bus.mask = 8'h00;
        ack_one("mask_released");
        check("mask_pend_done", 32'(bus.pend_o), 0);
        bus.req = '0;
        tick();

        // presented id stays stable while a higher priority line arrives
        exp_q.push_back(W'(5));
        exp_q.push_back(W'(0));
        bus.req = 8'h20;
        wait_valid("hold_first");
        bus.req = 8'h21;
        repeat (3) tick();
        check("hold_id_stable", 32'(bus.id_o), 5);
        check("hold_valid_stable", 32'(bus.valid_o), 1);
        check("hold_pend_both", 32'(bus.pend_o), 32'h21);
        ack_one("hold_ack5");
        ack_one("hold_ack0");
        check("hold_pend_done", 32'(bus.pend_o), 0);
        bus.req = '0;
        tick();

        // overflow pulse, then set-wins on the ack cycle
        exp_q.push_back(W'(3));
        bus.req = 8'h08;
        tick();
        check("ovf_first_edge", 32'(bus.overflow_o), 0);
        bus.req = 8'h00;
        tick();
        bus.req = 8'h08;
        tick();
        check("ovf_pulse", 32'(bus.overflow_o), 1);
        tick();
        check("ovf_one_cycle", 32'(bus.overflow_o), 0);
        bus.req = 8'h00;
        tick();
        exp_q.push_back(W'(3));
        bus.req = 8'h08;
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("setwin_pend", 32'(bus.pend_o), 32'h08);
        check("setwin_valid", 32'(bus.valid_o), 0);
        tick();
        check("setwin_no_ovf", 32'(bus.overflow_o), 0);
        ack_one("setwin_reissue");
        check("setwin_pend_done", 32'(bus.pend_o), 0);
        bus.req = '0;
        tick();

        // reset in the middle of a presentation
        exp_q.push_back(W'(0));
        bus.req = 8'hFF;
        tick();
        tick();
        check("mid_valid", 32'(bus.valid_o), 1);
        check("mid_pend", 32'(bus.pend_o), 32'hFF);
        tick();
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.valid_o), 0);
        check("mid_rst_pend", 32'(bus.pend_o), 0);
        check("mid_rst_id", 32'(bus.id_o), 0);
        check("mid_rst_ovf", 32'(bus.overflow_o), 0);
        tick();
        rstn = 1'b1;
        repeat (4) tick();
        check("post_rst_no_event_pend", 32'(bus.pend_o), 0);
        check("post_rst_no_event_valid", 32'(bus.valid_o), 0);
        bus.req = 8'h00;
        tick();
        exp_q.push_back(W'(1));
        bus.req = 8'h02;
        tick();
        check("post_rst_fresh_edge", 32'(bus.pend_o), 32'h02);
        ack_one("post_rst_ack");
        check("post_rst_pend_done", 32'(bus.pend_o), 0);
        bus.req = '0;
        repeat (3) tick();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
